register_pipe: RTL and testbench
================================

REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, giving the data width in bits (minimum 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (minimum 1).
REQ-003 Port iClk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port iRst  input  1  SHALL be the reset: asynchronous assertion, active-high.
REQ-005 Port iEn  input  1  SHALL be the global advance enable; when 0, the pipe is frozen.
REQ-006 Port iClr  input  1  SHALL be a synchronous flush of all stages.
REQ-007 Port iValid  input  1  SHALL mark iData as valid from upstream.
REQ-008 Port oReady  output  1  SHALL indicate the block accepts iData this cycle.
REQ-009 Port iData  input  BITWIDTH  SHALL be the upstream data.
REQ-010 Port oValid  output  1  SHALL mark oData as valid (last stage occupied).
REQ-011 Port iReady  input  1  SHALL indicate downstream accepts oData this cycle.
REQ-012 Port oData  output  BITWIDTH  SHALL be the last-stage data register.
REQ-013 Port oCount  output  $clog2(DEPTH+1)  SHALL report occupied stages (present only per REQ-030).

Function
REQ-014 Stage i SHALL hold a data register and a valid bit; stage 0 receives input; stage DEPTH-1 drives oData/oValid directly from flops.
REQ-015 Output transfer SHALL occur on an edge where oValid=1, iReady=1, iEn=1, iClr=0.
REQ-016 Stage i SHALL advance when iEn=1, iClr=0, and stage i+1 is empty or advancing; the last stage advances on output transfer or when empty.
REQ-017 oReady SHALL be iEn AND NOT iClr AND (stage 0 empty OR stage 0 advancing); combinational from the current state and iReady.
REQ-018 Input transfer SHALL occur on an edge where iValid=1 and oReady=1; the data is loaded into stage 0 with valid=1.
REQ-019 A stage that advances with no incoming data SHALL clear its valid bit and retain its data register.
REQ-020 Bubbles SHALL collapse: a valid entry SHALL move forward into an empty stage even while oValid=1 and iReady=0.
REQ-021 Latency SHALL be DEPTH cycles: data accepted at edge k is presented on oData with oValid=1 after edge k+DEPTH-1 if the path is unstalled.
REQ-022 Throughput SHALL be one transfer per cycle with iReady held 1; simultaneous input and output transfers SHALL both occur.
REQ-023 Order SHALL be preserved; no entry is dropped or duplicated under any stall pattern.
REQ-024 iEn=0 SHALL hold all stages and oCount; oReady=0; oValid/oData unchanged.
REQ-025 iClr=1 SHALL, on the next edge, clear every valid bit and every data register to 0, overriding iEn and both handshakes; no transfer occurs that cycle.
REQ-026 oData SHALL NOT change while oValid=1 and iReady=0.

Reset
REQ-027 Asserting iRst SHALL immediately clear every valid bit and data register to 0, without waiting for a clock edge.
REQ-028 Reset values SHALL be oValid=0, oData=0, oCount=0; oReady=0 while iRst=1 and equal to iEn AND NOT iClr after release.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight entries; the first edge after release with iValid=1 and oReady=1 SHALL accept normally.

Configuration
REQ-030 Macro REGISTER_PIPE_COUNT_EN defined: oCount SHALL equal the number of valid stages, updated each edge (+1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither, 0 on iClr/iRst); undefined: the oCount port and its counter SHALL be absent.

Verification
REQ-031 DEPTH=4, iRst 1->0, iEn=1, iReady=1, iValid=1 with iData 10,100,1000,10000 on consecutive cycles -> oData 10,100,1000,10000 with oValid=1 on the 4th..7th cycles after the first acceptance, oReady held 1.
REQ-032 Fill 4 entries (1..4) with iReady=0 -> oReady=0 after the 4th accept, oData=1 stable, oCount=4; then iReady=1 for 4 cycles -> 1,2,3,4 out in order, oCount falls to 0.
REQ-033 Load 2 entries (0xA, 0xB), then iClr=1 for one cycle with iValid=1 -> next edge oValid=0, oData=0, oCount=0, no 0xA/0xB emitted, input not accepted.
REQ-034 Stream 0x1..0x8 with iEn toggling 1,0,1,0 and random iReady -> all held during iEn=0, output sequence exactly 0x1..0x8.
REQ-035 Assert iRst between edges with 3 entries in flight -> oValid=0, oData=0 immediately; after release, first accepted word 0x55 emerges 4 cycles later.
REQ-036 DEPTH=1, BITWIDTH=8, iReady=1, iValid=1 -> one word per cycle, 1-cycle latency, oReady constant 1.

Source files
------------

// File: rtl/register_pipe.sv
// ---------------------------------------------------------------------------
// register_pipe
//
// Elastic register pipeline of DEPTH stages, each holding a data register and
// a valid bit. It uses a valid/ready handshake on both sides. Empty stages
// ("bubbles") are filled from behind even when the output is stalled, so a
// stalled pipe keeps accepting input until every stage is occupied. oData and
// oValid come straight from the last-stage flops.
//
// Optional feature:
//    REGISTER_PIPE_COUNT_EN  - when defined, adds the oCount port and an
//                              occupancy counter. When undefined, both are
//                              absent.
//
// Parameters:
//    BITWIDTH  data width in bits (>= 1)
//    DEPTH     number of register stages (>= 1)
//
// Ports:
//    iClk    in   rising-edge clock
//    iRst    in   asynchronous active-high reset (clears all stages)
//    iEn     in   global advance enable; 0 freezes the whole pipe
//    iClr    in   synchronous flush of all stages (valid and data to 0)
//    iValid  in   upstream data valid
//    oReady  out  the pipe accepts iData this cycle
//    iData   in   upstream data
//    oValid  out  last stage occupied
//    iReady  in   downstream accepts oData this cycle
//    oData   out  last-stage data register
//    oCount  out  number of occupied stages (REGISTER_PIPE_COUNT_EN only)
// ---------------------------------------------------------------------------
module register_pipe #(
   parameter int BITWIDTH = 32,
   parameter int DEPTH    = 4
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iEn,
   input  logic                iClr,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iData,
   output logic                oValid,
   input  logic                iReady,
   output logic [BITWIDTH-1:0] oData
`ifdef REGISTER_PIPE_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] oCount
`endif
);

   logic [BITWIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]    r_valid;

   logic                w_go;
   logic                w_sink;
   logic [DEPTH-1:0]    w_ld;
   logic [DEPTH-1:0]    w_src_valid;
   logic [BITWIDTH-1:0] w_src_data [DEPTH];

   assign w_go   = iEn & ~iClr;
   assign w_sink = w_go & iReady;

   // w_ld[i]: stage i takes whatever sits in front of it (stage i-1, or the
   // input for stage 0). That is allowed when the stage is empty or its own
   // content moves on. The next stage loading is the same thing as stage i
   // advancing, so one backward ripple from the sink covers both cases.
   always_comb begin : load_chain
      logic v_ld;
      w_ld = '0;
      v_ld = w_sink;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         v_ld    = w_go & (~r_valid[i] | v_ld);
         w_ld[i] = v_ld;
      end
   end

   always_comb begin : stage_sources
      w_src_valid[0] = iValid;
      w_src_data[0]  = iData;
      for (int i = 1; i < DEPTH; i++) begin
         w_src_valid[i] = r_valid[i-1];
         w_src_data[i]  = r_data[i-1];
      end
   end

   // A loading stage whose source is empty becomes a bubble. It keeps its old
   // data so that oData does not toggle needlessly.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
      end else if (iClr) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_ld[i]) begin
               r_valid[i] <= w_src_valid[i];
               if (w_src_valid[i]) begin
                  r_data[i] <= w_src_data[i];
               end
            end
         end
      end
   end

   // Reset gating keeps oReady low for the whole time iRst is asserted, even
   // though the cleared stages alone would report "ready".
   assign oReady = w_ld[0] & ~iRst;
   assign oValid = r_valid[DEPTH-1];
   assign oData  = r_data[DEPTH-1];

`ifdef REGISTER_PIPE_COUNT_EN
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] r_count;
   logic          w_in_xfer;
   logic          w_out_xfer;

   assign w_in_xfer  = iValid & oReady;
   assign w_out_xfer = r_valid[DEPTH-1] & w_sink;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_count <= '0;
      end else if (iClr) begin
         r_count <= '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         r_count <= r_count + CW'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign oCount = r_count;
`endif

endmodule

// File: tb/tb_register_pipe.sv
module tb_register_pipe;

   localparam int D = 4;
   localparam int W = 32;

   logic          iClk = 1'b0;
   logic          iRst = 1'b1;
   logic          iEn = 1'b1;
   logic          iClr = 1'b0;
   logic          iValid = 1'b0;
   logic          iReady = 1'b0;
   logic [W-1:0]  iData = '0;
   logic          oReady;
   logic          oValid;
   logic [W-1:0]  oData;

   logic          d1_en = 1'b1;
   logic          d1_clr = 1'b0;
   logic          d1_valid = 1'b0;
   logic          d1_ready = 1'b1;
   logic [7:0]    d1_data = '0;
   logic          d1_oReady;
   logic          d1_oValid;
   logic [7:0]    d1_oData;

`ifdef REGISTER_PIPE_COUNT_EN
   logic [2:0]    oCount;
   logic          d1_oCount;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 iClk = ~iClk;

   register_pipe #(.BITWIDTH(W), .DEPTH(D)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid),
      .oReady(oReady), .iData(iData), .oValid(oValid), .iReady(iReady),
      .oData(oData)
`ifdef REGISTER_PIPE_COUNT_EN
      , .oCount(oCount)
`endif
   );

   register_pipe #(.BITWIDTH(8), .DEPTH(1)) dut_d1 (
      .iClk(iClk), .iRst(iRst), .iEn(d1_en), .iClr(d1_clr), .iValid(d1_valid),
      .oReady(d1_oReady), .iData(d1_data), .oValid(d1_oValid), .iReady(d1_ready),
      .oData(d1_oData)
`ifdef REGISTER_PIPE_COUNT_EN
      , .oCount(d1_oCount)
`endif
   );

   // Reference model: ordered queue of entries (oldest first), each with its
   // stage position. Each advancing edge, the oldest entry leaves if it sits
   // at the last stage and downstream is ready. Every other entry moves one
   // stage forward, but never into or past the entry ahead of it.
   logic [W-1:0] m_data [$];
   int           m_pos [$];
   logic [W-1:0] m_last;

   function automatic void model_reset();
      m_data.delete();
      m_pos.delete();
      m_last = '0;
   endfunction

   function automatic bit model_ready_f(bit en, bit clr, bit rdy);
      int lim;
      int s;
      int np;
      if (!en || clr) return 1'b0;
      s = 0;
      if (m_pos.size() > 0 && m_pos[0] == D - 1 && rdy) s = 1;
      lim = D - 1;
      for (int i = s; i < m_pos.size(); i++) begin
         np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
         lim = np - 1;
      end
      return lim >= 0;
   endfunction

   function automatic void model_edge(bit en, bit clr, bit valid, logic [W-1:0] data, bit rdy);
      bit acc;
      int lim;
      int np;
      if (clr) begin
         model_reset();
         return;
      end
      if (!en) return;
      acc = valid && model_ready_f(1'b1, 1'b0, rdy);
      if (m_pos.size() > 0 && m_pos[0] == D - 1 && rdy) begin
         void'(m_pos.pop_front());
         void'(m_data.pop_front());
      end
      lim = D - 1;
      for (int i = 0; i < m_pos.size(); i++) begin
         np = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
         m_pos[i] = np;
         if (np == D - 1) m_last = m_data[i];
         lim = np - 1;
      end
      if (acc) begin
         m_data.push_back(data);
         m_pos.push_back(0);
         if (D == 1) m_last = data;
      end
   endfunction

   function automatic bit model_valid();
      return (m_pos.size() > 0) && (m_pos[0] == D - 1);
   endfunction

   task automatic tick();
      @(posedge iClk);
      if (iRst) model_reset();
      else model_edge(iEn, iClr, iValid, iData, iReady);
      #1;
   endtask

   task automatic do_reset();
      iRst = 1'b1;
      iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0;
      tick();
      iRst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b1; iReady = 1'b1;
      tick();
      tick();
      n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_oValid got=%b exp=0", oValid); end
      n_checks++; if (oData !== '0) begin n_fail++; $display("FAIL reset_oData got=%h exp=0", oData); end
      n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL reset_oReady_in_rst got=%b exp=0", oReady); end
`ifdef REGISTER_PIPE_COUNT_EN
      n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL reset_oCount got=%0d exp=0", oCount); end
`endif
      iValid = 1'b0;
      iRst = 1'b0;
      #1;
      n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL reset_oReady_release got=%b exp=1", oReady); end
      iEn = 1'b0;
      #1;
      n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL reset_oReady_en0 got=%b exp=0", oReady); end
      iEn = 1'b1; iClr = 1'b1;
      #1;
      n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL reset_oReady_clr got=%b exp=0", oReady); end
      iClr = 1'b0;
   endtask

   task automatic test_latency();
      logic [W-1:0] tbl [4];
      bit           exp_v;
      tbl = '{32'd10, 32'd100, 32'd1000, 32'd10000};
      do_reset();
      iReady = 1'b1;
      for (int c = 0; c < 9; c++) begin
         iValid = (c < 4);
         iData  = (c < 4) ? tbl[c] : $urandom;
         @(negedge iClk);
         exp_v = (c >= 4 && c <= 7);
         n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL latency_oReady c=%0d got=%b exp=1", c, oReady); end
         n_checks++; if (oValid !== exp_v) begin n_fail++; $display("FAIL latency_oValid c=%0d got=%b exp=%b", c, oValid, exp_v); end
         if (exp_v) begin
            n_checks++; if (oData !== tbl[c-4]) begin n_fail++; $display("FAIL latency_oData c=%0d got=%0d exp=%0d", c, oData, tbl[c-4]); end
         end
         tick();
      end
      iValid = 1'b0;
   endtask

   task automatic test_fill_stall();
      do_reset();
      iReady = 1'b0;
      for (int c = 0; c < 4; c++) begin
         iValid = 1'b1;
         iData  = W'(c + 1);
         tick();
      end
      iValid = 1'b1;
      iData  = 32'h99;
      for (int c = 0; c < 2; c++) begin
         @(negedge iClk);
         n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL fill_oReady got=%b exp=0", oReady); end
         n_checks++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL fill_oValid got=%b exp=1", oValid); end
         n_checks++; if (oData !== 32'd1) begin n_fail++; $display("FAIL fill_oData got=%0d exp=1", oData); end
`ifdef REGISTER_PIPE_COUNT_EN
         n_checks++; if (oCount !== 3'd4) begin n_fail++; $display("FAIL fill_oCount got=%0d exp=4", oCount); end
`endif
         tick();
      end
      iValid = 1'b0;
      iReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge iClk);
         n_checks++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL drain_oValid c=%0d got=%b exp=1", c, oValid); end
         n_checks++; if (oData !== W'(c + 1)) begin n_fail++; $display("FAIL drain_oData c=%0d got=%0d exp=%0d", c, oData, c + 1); end
`ifdef REGISTER_PIPE_COUNT_EN
         n_checks++; if (oCount !== 3'(4 - c)) begin n_fail++; $display("FAIL drain_oCount c=%0d got=%0d exp=%0d", c, oCount, 4 - c); end
`endif
         tick();
      end
      @(negedge iClk);
      n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_oValid got=%b exp=0", oValid); end
`ifdef REGISTER_PIPE_COUNT_EN
      n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL drain_empty_oCount got=%0d exp=0", oCount); end
`endif
   endtask

   task automatic test_clear();
      do_reset();
      iReady = 1'b0;
      iValid = 1'b1; iData = 32'hA; tick();
      iData = 32'hB; tick();
      iClr = 1'b1; iValid = 1'b1; iData = 32'hC; iReady = 1'b1;
      @(negedge iClk);
      n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL clr_oReady got=%b exp=0", oReady); end
      tick();
      iClr = 1'b0; iValid = 1'b0;
      n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL clr_oValid got=%b exp=0", oValid); end
      n_checks++; if (oData !== '0) begin n_fail++; $display("FAIL clr_oData got=%h exp=0", oData); end
`ifdef REGISTER_PIPE_COUNT_EN
      n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL clr_oCount got=%0d exp=0", oCount); end
`endif
      for (int c = 0; c < 6; c++) begin
         @(negedge iClk);
         n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL clr_nothing_emitted c=%0d oValid=%b oData=%h exp_valid=0", c, oValid, oData); end
         tick();
      end
   endtask

   task automatic test_enable_toggle();
      logic [W-1:0] got [$];
      int  sent;
      bit  exp_rdy;
      bit  exp_v;
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 200 && got.size() < 8; cyc++) begin
         iEn    = (cyc % 2 == 0);
         iReady = 1'($urandom_range(0, 1));
         iValid = (sent < 8);
         iData  = W'(sent + 1);
         @(negedge iClk);
         exp_rdy = model_ready_f(iEn, iClr, iReady);
         exp_v   = model_valid();
         n_checks++; if (oReady !== exp_rdy) begin n_fail++; $display("FAIL en_oReady cyc=%0d got=%b exp=%b", cyc, oReady, exp_rdy); end
         n_checks++; if (oValid !== exp_v) begin n_fail++; $display("FAIL en_oValid cyc=%0d got=%b exp=%b", cyc, oValid, exp_v); end
         n_checks++; if (oData !== m_last) begin n_fail++; $display("FAIL en_oData cyc=%0d got=%h exp=%h", cyc, oData, m_last); end
         if (oValid && iReady && iEn) got.push_back(oData);
         if (iValid && exp_rdy) sent++;
         tick();
      end
      iEn = 1'b1; iValid = 1'b0;
      n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL en_out_count got=%0d exp=8", got.size()); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         n_checks++; if (got[i] !== W'(i + 1)) begin n_fail++; $display("FAIL en_order idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      iReady = 1'b0;
      iValid = 1'b1; iData = 32'h11; tick();
      iData = 32'h22; tick();
      iData = 32'h33; tick();
      iValid = 1'b0;
      tick();
      @(negedge iClk);
      n_checks++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_oValid got=%b exp=1", oValid); end
      #2;
      iRst = 1'b1;
      #1;
      n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL arst_oValid got=%b exp=0", oValid); end
      n_checks++; if (oData !== '0) begin n_fail++; $display("FAIL arst_oData got=%h exp=0", oData); end
      n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL arst_oReady got=%b exp=0", oReady); end
`ifdef REGISTER_PIPE_COUNT_EN
      n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL arst_oCount got=%0d exp=0", oCount); end
`endif
      model_reset();
      tick();
      iRst = 1'b0;
      iValid = 1'b1; iData = 32'h55; iReady = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge iClk);
         if (c == 0) begin
            n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL arst_accept_oReady got=%b exp=1", oReady); end
         end
         n_checks++; if (oValid !== (c == 4)) begin n_fail++; $display("FAIL arst_out_oValid c=%0d got=%b exp=%b", c, oValid, (c == 4)); end
         if (c == 4) begin
            n_checks++; if (oData !== 32'h55) begin n_fail++; $display("FAIL arst_out_oData got=%h exp=55", oData); end
         end
         tick();
         iValid = 1'b0;
      end
   endtask

   task automatic test_depth1();
      logic [7:0] prev;
      do_reset();
      d1_en = 1'b1; d1_clr = 1'b0; d1_ready = 1'b1; d1_valid = 1'b1;
      prev = '0;
      for (int c = 0; c < 10; c++) begin
         d1_data = 8'($urandom_range(0, 255));
         @(negedge iClk);
         n_checks++; if (d1_oReady !== 1'b1) begin n_fail++; $display("FAIL d1_oReady c=%0d got=%b exp=1", c, d1_oReady); end
         if (c > 0) begin
            n_checks++; if (d1_oValid !== 1'b1) begin n_fail++; $display("FAIL d1_oValid c=%0d got=%b exp=1", c, d1_oValid); end
            n_checks++; if (d1_oData !== prev) begin n_fail++; $display("FAIL d1_oData c=%0d got=%h exp=%h", c, d1_oData, prev); end
`ifdef REGISTER_PIPE_COUNT_EN
            n_checks++; if (d1_oCount !== 1'b1) begin n_fail++; $display("FAIL d1_oCount c=%0d got=%b exp=1", c, d1_oCount); end
`endif
         end
         tick();
         prev = d1_data;
      end
      d1_valid = 1'b0;
      tick();
      @(negedge iClk);
      n_checks++; if (d1_oValid !== 1'b0) begin n_fail++; $display("FAIL d1_drain_oValid got=%b exp=0", d1_oValid); end
      n_checks++; if (d1_oData !== prev) begin n_fail++; $display("FAIL d1_retain_oData got=%h exp=%h", d1_oData, prev); end
   endtask

   task automatic test_random();
      bit exp_rdy;
      bit exp_v;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         iEn    = ($urandom_range(0, 3) != 0);
         iClr   = ($urandom_range(0, 31) == 0);
         iValid = 1'($urandom_range(0, 1));
         iReady = ($urandom_range(0, 2) != 0);
         iData  = $urandom;
         @(negedge iClk);
         exp_rdy = model_ready_f(iEn, iClr, iReady);
         exp_v   = model_valid();
         n_checks++; if (oReady !== exp_rdy) begin n_fail++; $display("FAIL rnd_oReady cyc=%0d got=%b exp=%b", cyc, oReady, exp_rdy); end
         n_checks++; if (oValid !== exp_v) begin n_fail++; $display("FAIL rnd_oValid cyc=%0d got=%b exp=%b", cyc, oValid, exp_v); end
         n_checks++; if (oData !== m_last) begin n_fail++; $display("FAIL rnd_oData cyc=%0d got=%h exp=%h", cyc, oData, m_last); end
`ifdef REGISTER_PIPE_COUNT_EN
         n_checks++; if (oCount !== 3'(m_pos.size())) begin n_fail++; $display("FAIL rnd_oCount cyc=%0d got=%0d exp=%0d", cyc, oCount, m_pos.size()); end
`endif
         tick();
      end
      iEn = 1'b1; iClr = 1'b0; iValid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_latency();
      test_fill_stall();
      test_clear();
      test_enable_toggle();
      test_async_reset();
      test_depth1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
